// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data memory for the RV32 datapath.
//
// Handles byte/half/word loads and stores through a valid/ready request
// handshake. Load data is sign- or zero-extended and returned through a
// fixed-latency response pipeline of READ_LAT (1 or 2) cycles. Misaligned,
// illegal-size and out-of-range requests fault and never touch the array.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  block can accept a request (1 from first edge after reset)
//   req_write    in   1 = store, 0 = load
//   req_size     in   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned in   loads: 1 = zero-extend, 0 = sign-extend
//   req_addr     in   byte address
//   req_wdata    in   right-aligned store data
//   rsp_valid    out  response present, READ_LAT cycles after acceptance
//   rsp_rdata    out  extended load data, 0 for stores, faults and idle cycles
//   rsp_fault    out  request faulted
//   fault_count  out  saturating count of faulted responses
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [7:0]  fault_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Shift the selected lane down to bit 0 already done by the caller; this
  // only extends the low byte/half to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] v,
                                              input logic [1:0]  sz,
                                              input logic        uns);
    case (sz)
      2'b00:   return uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic             ready_q;
  logic             acc;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             fault_d;
  logic [31:0]      rd_word;
  logic [31:0]      rdata_d;

  logic             s1_vld_q, s1_fault_q;
  logic [31:0]      s1_rdata_q;
  logic             s2_vld_q, s2_fault_q;
  logic [31:0]      s2_rdata_q;
  logic [7:0]       cnt_q;
  logic             fin_fault;

  assign req_ready = ready_q;
  assign acc       = req_valid && ready_q;
  assign idx       = req_addr[IDX_W+1:2];
  assign lane      = req_addr[1:0];

  always_comb begin
    fault_d = 1'b0;
    case (req_size)
      2'b01:   fault_d = lane[0];
      2'b10:   fault_d = (lane != 2'b00);
      2'b11:   fault_d = 1'b1;
      default: fault_d = 1'b0;
    endcase
    // Any address bit above the word-index field means out of range.
    if (req_addr[31:IDX_W+2] != '0) fault_d = 1'b1;
  end

  // Array read is combinational in the request cycle; the lane shift
  // brings the addressed byte/half to bit 0 before extension.
  assign rd_word = mem_q[idx];
  assign rdata_d = (acc && !req_write && !fault_d)
                   ? extend_load(rd_word >> {lane, 3'b000}, req_size, req_unsigned)
                   : 32'h0;

  // Array itself is never reset, so a store on the last edge before reset
  // stays written.
  always_ff @(posedge clk) begin
    if (acc && req_write && !fault_d) begin
      case (req_size)
        2'b00:   mem_q[idx][{lane, 3'b000} +: 8]        <= req_wdata[7:0];
        2'b01:   mem_q[idx][{lane[1], 4'b0000} +: 16]   <= req_wdata[15:0];
        default: mem_q[idx]                             <= req_wdata;
      endcase
    end
  end

  // fault_count must move on the edge that makes the faulted response
  // visible, i.e. the load of the last pipeline stage.
  assign fin_fault = (READ_LAT == 2) ? (s1_vld_q && s1_fault_q)
                                     : (acc && fault_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_fault_q <= 1'b0;
      s1_rdata_q <= 32'h0;
      s2_vld_q   <= 1'b0;
      s2_fault_q <= 1'b0;
      s2_rdata_q <= 32'h0;
      cnt_q      <= 8'h0;
    end else begin
      ready_q    <= 1'b1;
      // Stage 1: registered array read
      s1_vld_q   <= acc;
      s1_fault_q <= acc && fault_d;
      s1_rdata_q <= rdata_d;
      // Stage 2: optional extra output register
      if (READ_LAT == 2) begin
        s2_vld_q   <= s1_vld_q;
        s2_fault_q <= s1_fault_q;
        s2_rdata_q <= s1_rdata_q;
      end
      if (fin_fault && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'h1;
    end
  end

  assign rsp_valid   = (READ_LAT == 2) ? s2_vld_q   : s1_vld_q;
  assign rsp_fault   = (READ_LAT == 2) ? s2_fault_q : s1_fault_q;
  assign rsp_rdata   = (READ_LAT == 2) ? s2_rdata_q : s1_rdata_q;
  assign fault_count = cnt_q;

endmodule
